acia_rx_fifo: RTL and testbench

ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

---
 rtl/acia_rx_fifo_if.sv | 30 +++
 rtl/acia_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_acia_rx_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/acia_rx_fifo_if.sv
// Bus between the ACIA receiver/host side and the receive FIFO.
// The master drives received bytes and host strobes; the slave (FIFO) returns
// the handshake acknowledge, head-of-queue data and status.
interface acia_rx_fifo_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  RXDATA;
  logic        RXFULL;
  logic        FRAME;
  logic        PARITY;
  logic        RXTAKEN;
  logic        POP;
  logic        CLR_OVF;
  logic [7:0]  DOUT;
  logic [1:0]  DERR;
  logic        EMPTY;
  logic        FULL;
  logic [AW:0] COUNT;
  logic        OVF;

  modport master (
    output RXDATA, RXFULL, FRAME, PARITY, POP, CLR_OVF,
    input  RXTAKEN, DOUT, DERR, EMPTY, FULL, COUNT, OVF
  );

  modport slave (
    input  RXDATA, RXFULL, FRAME, PARITY, POP, CLR_OVF,
    output RXTAKEN, DOUT, DERR, EMPTY, FULL, COUNT, OVF
  );
endinterface

// File: rtl/acia_rx_fifo.sv
// ACIA receive FIFO: captures one byte per RXFULL assertion into a 2**AW deep
// queue of {FRAME, PARITY, DATA}, acknowledges via RXTAKEN, presents the head
// entry first-word fall-through and flags blocked bytes with a sticky OVF.
// All state changes on the falling edge of PHI2.
module acia_rx_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic              PHI2,
  input  logic              RESET,
  acia_rx_fifo_if.slave     bus
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]    r_state;
  logic          r_rxtaken;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  logic [9:0]    r_mem [DEPTH];

  logic          w_capture_state;
  logic          w_pop;
  logic          w_wr;
  logic          w_block;
  logic [AW:0]   w_count_nxt;
  logic [9:0]    w_head;

  // Pop only when something is held; a pop on an empty FIFO is ignored.
  // Writing into a full FIFO is legal when the head leaves on the same edge.
  always_comb begin
    w_capture_state = (r_state == ST_IDLE) || (r_state == ST_STALL);
    w_pop           = bus.POP && !r_empty;
    w_wr            = w_capture_state && bus.RXFULL && (!r_full || bus.POP);
    w_block         = (r_state == ST_IDLE) && bus.RXFULL && r_full && !bus.POP;
  end

  // Next occupancy from the write/pop pair; simultaneous write+pop is neutral.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Capture handshake FSM: one write per RXFULL assertion, RXTAKEN held
  // until RXFULL is seen low, STALL while a byte waits on a full FIFO.
  always_ff @(negedge PHI2) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_rxtaken <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr) begin
            r_state   <= ST_ACK;
            r_rxtaken <= 1'b1;
          end else if (w_block) begin
            r_state   <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (!bus.RXFULL) begin
            r_state <= ST_IDLE;
          end else if (w_wr) begin
            r_state   <= ST_ACK;
            r_rxtaken <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!bus.RXFULL) begin
            r_state   <= ST_IDLE;
            r_rxtaken <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rxtaken <= 1'b0;
        end
      endcase
    end
  end

  // Pointer and occupancy bookkeeping; EMPTY/FULL registered from next count.
  always_ff @(negedge PHI2) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_MAX);
    end
  end

  // Storage write; contents are never cleared since they are hidden while empty.
  always_ff @(negedge PHI2) begin
    if (!RESET && w_wr)
      r_mem[r_wr_ptr] <= {bus.FRAME, bus.PARITY, bus.RXDATA};
  end

  // Sticky overflow: a new block event wins over a same-edge clear.
  always_ff @(negedge PHI2) begin
    if (RESET)
      r_ovf <= 1'b0;
    else if (w_block)
      r_ovf <= 1'b1;
    else if (bus.CLR_OVF)
      r_ovf <= 1'b0;
  end

  // Head entry fall-through, forced to zero while empty.
  always_comb begin
    w_head = r_empty ? '0 : r_mem[r_rd_ptr];
  end

  assign bus.RXTAKEN = r_rxtaken;
  assign bus.DOUT    = w_head[7:0];
  assign bus.DERR    = w_head[9:8];
  assign bus.EMPTY   = r_empty;
  assign bus.FULL    = r_full;
  assign bus.COUNT   = r_count;
  assign bus.OVF     = r_ovf;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo: single byte, fill/overflow, full with
// simultaneous pop, error flags, reset during ACK and OVF clear priority.
`timescale 1ns/1ps
module tb_acia_rx_fifo;

  localparam int unsigned AW = 3;

  logic PHI2;
  logic RESET;
  int   n_checks;
  int   n_fail;

  acia_rx_fifo_if #(.AW(AW)) bus ();

  acia_rx_fifo #(.AW(AW)) dut (
    .PHI2  (PHI2),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial PHI2 = 1'b1;
  always #5 PHI2 = ~PHI2;

  // Active edge is the falling edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(negedge PHI2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte for one edge (captured), then drop RXFULL for one edge (ACK->IDLE).
  task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe);
    bus.RXDATA = d;
    bus.FRAME  = fe;
    bus.PARITY = pe;
    bus.RXFULL = 1'b1;
    tick();
    bus.RXFULL = 1'b0;
    bus.FRAME  = 1'b0;
    bus.PARITY = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d;
    n_checks = 0;
    n_fail   = 0;
    RESET       = 1'b1;
    bus.RXDATA  = '0;
    bus.RXFULL  = 1'b0;
    bus.FRAME   = 1'b0;
    bus.PARITY  = 1'b0;
    bus.POP     = 1'b0;
    bus.CLR_OVF = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    chk("rst_count",   32'(bus.COUNT), 0);
    chk("rst_empty",   32'(bus.EMPTY), 1);
    chk("rst_full",    32'(bus.FULL), 0);
    chk("rst_ovf",     32'(bus.OVF), 0);
    chk("rst_rxtaken", 32'(bus.RXTAKEN), 0);
    chk("rst_dout",    32'(bus.DOUT), 0);
    chk("rst_derr",    32'(bus.DERR), 0);

    // Single byte, RXFULL held for 3 edges
    bus.RXDATA = 8'hA5;
    bus.RXFULL = 1'b1;
    tick();
    chk("sb_taken1", 32'(bus.RXTAKEN), 1);
    chk("sb_count1", 32'(bus.COUNT), 1);
    chk("sb_empty",  32'(bus.EMPTY), 0);
    chk("sb_dout",   32'(bus.DOUT), 32'hA5);
    chk("sb_derr",   32'(bus.DERR), 0);
    tick();
    chk("sb_taken2", 32'(bus.RXTAKEN), 1);
    tick();
    chk("sb_taken3", 32'(bus.RXTAKEN), 1);
    chk("sb_count3", 32'(bus.COUNT), 1);
    bus.RXFULL = 1'b0;
    tick();
    chk("sb_taken_low", 32'(bus.RXTAKEN), 0);
    chk("sb_count_once", 32'(bus.COUNT), 1);
    bus.POP = 1'b1;
    tick();
    bus.POP = 1'b0;
    chk("sb_pop_empty", 32'(bus.EMPTY), 1);
    chk("sb_pop_dout",  32'(bus.DOUT), 0);
    chk("sb_pop_count", 32'(bus.COUNT), 0);

    // Fill 01..08
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill_full",  32'(bus.FULL), 1);
    chk("fill_count", 32'(bus.COUNT), 8);
    chk("fill_head",  32'(bus.DOUT), 32'h01);

    // Ninth byte blocks
    bus.RXDATA = 8'h09;
    bus.RXFULL = 1'b1;
    tick();
    chk("blk_ovf",   32'(bus.OVF), 1);
    chk("blk_taken", 32'(bus.RXTAKEN), 0);
    chk("blk_count", 32'(bus.COUNT), 8);
    tick();
    chk("stall_taken", 32'(bus.RXTAKEN), 0);
    bus.POP = 1'b1;
    tick();
    bus.POP = 1'b0;
    chk("stall_cap_taken", 32'(bus.RXTAKEN), 1);
    chk("stall_cap_count", 32'(bus.COUNT), 8);
    chk("stall_cap_head",  32'(bus.DOUT), 32'h02);
    bus.RXFULL = 1'b0;
    tick();
    chk("stall_ack_low", 32'(bus.RXTAKEN), 0);

    // CLR_OVF alone clears
    bus.CLR_OVF = 1'b1;
    tick();
    bus.CLR_OVF = 1'b0;
    chk("clr_ovf", 32'(bus.OVF), 0);

    // Full with simultaneous POP and RXFULL in IDLE
    bus.RXDATA = 8'h0A;
    bus.RXFULL = 1'b1;
    bus.POP    = 1'b1;
    tick();
    bus.POP = 1'b0;
    chk("fp_taken", 32'(bus.RXTAKEN), 1);
    chk("fp_ovf",   32'(bus.OVF), 0);
    chk("fp_count", 32'(bus.COUNT), 8);
    chk("fp_head",  32'(bus.DOUT), 32'h03);
    bus.RXFULL = 1'b0;
    tick();

    // Block, then clear on the same edge as another block: set wins
    bus.RXDATA = 8'h0B;
    bus.RXFULL = 1'b1;
    tick();
    chk("ovf_set", 32'(bus.OVF), 1);
    bus.RXFULL = 1'b0;
    tick();
    bus.RXDATA  = 8'h0C;
    bus.RXFULL  = 1'b1;
    bus.CLR_OVF = 1'b1;
    tick();
    bus.CLR_OVF = 1'b0;
    chk("ovf_set_wins", 32'(bus.OVF), 1);
    bus.RXFULL = 1'b0;
    tick();
    chk("ovf_hold", 32'(bus.OVF), 1);
    bus.CLR_OVF = 1'b1;
    tick();
    bus.CLR_OVF = 1'b0;
    chk("ovf_clear", 32'(bus.OVF), 0);

    // Drain in arrival order 03..0A
    for (int i = 3; i <= 10; i++) begin
      exp_d = 8'(i);
      chk($sformatf("drain_%0d", i), 32'(bus.DOUT), 32'(exp_d));
      bus.POP = 1'b1;
      tick();
      bus.POP = 1'b0;
    end
    chk("drain_empty", 32'(bus.EMPTY), 1);
    chk("drain_count", 32'(bus.COUNT), 0);

    // Error flags
    send_byte(8'h3C, 1'b1, 1'b1);
    chk("err_dout", 32'(bus.DOUT), 32'h3C);
    chk("err_derr", 32'(bus.DERR), 32'h3);
    bus.POP = 1'b1;
    tick();
    chk("err_pop_empty", 32'(bus.EMPTY), 1);
    tick();
    bus.POP = 1'b0;
    chk("empty_pop_count", 32'(bus.COUNT), 0);
    chk("empty_pop_derr",  32'(bus.DERR), 0);

    // Reset while in ACK with three entries
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    bus.RXDATA = 8'h33;
    bus.RXFULL = 1'b1;
    tick();
    chk("ra_count3", 32'(bus.COUNT), 3);
    chk("ra_taken",  32'(bus.RXTAKEN), 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("ra_count0", 32'(bus.COUNT), 0);
    chk("ra_empty",  32'(bus.EMPTY), 1);
    chk("ra_taken0", 32'(bus.RXTAKEN), 0);
    chk("ra_dout",   32'(bus.DOUT), 0);
    chk("ra_full",   32'(bus.FULL), 0);
    tick();
    chk("ra_recap_count", 32'(bus.COUNT), 1);
    chk("ra_recap_dout",  32'(bus.DOUT), 32'h33);
    chk("ra_recap_taken", 32'(bus.RXTAKEN), 1);
    bus.RXFULL = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
